lsu_ctrl: RTL and testbench

- Load/store controller sitting directly upstream of the data memory.
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Converts each request into memory cycles that use only even word addresses: byte loads, byte stores via read-modify-write, and misaligned word accesses split into two word accesses.
- Returns one response per request; load data is extracted and extended.

---
 rtl/lsu_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store controller: byte, word and misaligned accesses on an even-word memory
// Byte stores use read-modify-write; misaligned words are split into two word accesses.
module lsu_ctrl #(
  parameter int AW = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic          req_byte,
  input  logic          req_sext,
  input  logic [AW-1:0] req_addr,
  input  logic [15:0]   req_wdata,
  output logic          resp_valid,
  output logic [15:0]   resp_rdata,
  output logic [AW-1:0] addrm,
  output logic [15:0]   wmdata,
  output logic          re,
  output logic          we,
  output logic          mem_alu,
  input  logic [15:0]   rwdata
);

  typedef enum logic [2:0] {IDLE, RD0, WR0, RD1, WR1, RESP} state_t;

  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   wdata_q;
  logic [15:0]   h0_q;
  logic [15:0]   h1_q;
  logic [15:0]   rdata_q;
  logic          st_q;
  logic          byte_q;
  logic          sext_q;

  logic [AW-1:0] e_addr;
  logic [AW-1:0] e2_addr;
  logic          mis;
  logic [7:0]    byte_sel;
  logic [15:0]   load0_d;
  logic          re_d;
  logic          we_d;

  assign e_addr  = {addr_q[AW-1:1], 1'b0};
  assign e2_addr = e_addr + AW'(2);
  assign mis     = ~byte_q & addr_q[0];

  // Result of a single-word load, taken straight from the memory word as it is captured into H0.
  always_comb begin
    byte_sel = addr_q[0] ? rwdata[15:8] : rwdata[7:0];
    load0_d  = rwdata;
    if (byte_q) begin
      load0_d = sext_q ? {{8{byte_sel[7]}}, byte_sel} : {8'h00, byte_sel};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      h0_q    <= '0;
      h1_q    <= '0;
      rdata_q <= '0;
      st_q    <= 1'b0;
      byte_q  <= 1'b0;
      sext_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            st_q    <= req_we;
            byte_q  <= req_byte;
            sext_q  <= req_sext;
            state_q <= (req_we && !req_byte && !req_addr[0]) ? WR0 : RD0;
          end
        end
        RD0: begin
          h0_q <= rwdata;
          if (st_q) begin
            state_q <= WR0;
          end else if (mis) begin
            state_q <= RD1;
          end else begin
            rdata_q <= load0_d;
            state_q <= RESP;
          end
        end
        WR0: begin
          if (mis) begin
            state_q <= RD1;
          end else begin
            rdata_q <= '0;
            state_q <= RESP;
          end
        end
        RD1: begin
          h1_q <= rwdata;
          if (st_q) begin
            state_q <= WR1;
          end else begin
            rdata_q <= {rwdata[7:0], h0_q[15:8]};
            state_q <= RESP;
          end
        end
        WR1: begin
          rdata_q <= '0;
          state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    addrm   = '0;
    wmdata  = '0;
    re_d    = 1'b0;
    we_d    = 1'b0;
    mem_alu = 1'b1;
    case (state_q)
      RD0: begin
        addrm   = e_addr;
        re_d    = 1'b1;
        mem_alu = 1'b0;
      end
      RD1: begin
        addrm   = e2_addr;
        re_d    = 1'b1;
        mem_alu = 1'b0;
      end
      WR0: begin
        addrm = e_addr;
        we_d  = 1'b1;
        if (!byte_q && !addr_q[0]) begin
          wmdata = wdata_q;
        end else if (byte_q && !addr_q[0]) begin
          wmdata = {h0_q[15:8], wdata_q[7:0]};
        end else begin
          wmdata = {wdata_q[7:0], h0_q[7:0]};
        end
      end
      WR1: begin
        addrm  = e2_addr;
        we_d   = 1'b1;
        wmdata = {h1_q[15:8], wdata_q[15:8]};
      end
      default: ;
    endcase
  end

  // Strobes drop immediately on reset so a write in flight never commits.
  assign re         = re_d & reset_n;
  assign we         = we_d & reset_n;
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl with a byte memory model and response scoreboard
module tb_lsu_ctrl;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_byte;
  logic        req_sext;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [15:0] addrm;
  logic [15:0] wmdata;
  logic        re;
  logic        we;
  logic        mem_alu;
  logic [15:0] rwdata;

  logic [7:0]  mem [0:65535];
  logic [15:0] sb_q [$];
  logic [15:0] trace [$];
  logic [15:0] last_wm;
  int          n_vec;
  int          n_bad;

  lsu_ctrl #(.AW(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_byte   (req_byte),
    .req_sext   (req_sext),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .addrm      (addrm),
    .wmdata     (wmdata),
    .re         (re),
    .we         (we),
    .mem_alu    (mem_alu),
    .rwdata     (rwdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign rwdata = {mem[addrm + 16'd1], mem[addrm]};

  always @(posedge clock) begin
    if (we) begin
      mem[addrm]         <= wmdata[7:0];
      mem[addrm + 16'd1] <= wmdata[15:8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clock) begin
    if (resp_valid) begin
      if (sb_q.size() == 0) check("spurious_resp", 32'd1, 32'd0);
      else check("resp_rdata", {16'h0, resp_rdata}, {16'h0, sb_q.pop_front()});
    end
  end

  task automatic do_req(input logic w, input logic b, input logic sx, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] exp_rd, input int exp_lat,
                        input logic [15:0] t0, input logic [15:0] t1, input logic [15:0] t2,
                        input logic [15:0] t3, input int ntr, input bit hold_busy);
    logic [15:0] tx [4];
    int lat;
    tx = '{t0, t1, t2, t3};
    trace.delete();
    @(negedge clock);
    req_valid = 1'b1; req_we = w; req_byte = b; req_sext = sx; req_addr = a; req_wdata = wd;
    sb_q.push_back(exp_rd);
    @(posedge clock);
    #1;
    if (hold_busy) begin
      req_we = 1'b1; req_byte = 1'b0; req_addr = 16'h0050; req_wdata = 16'hDEAD;
    end else begin
      req_valid = 1'b0;
    end
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clock);
      if (hold_busy) check("busy_ready", {31'h0, req_ready}, 32'd0);
      if (re || we) trace.push_back(addrm);
      if (we) last_wm = wmdata;
      if (resp_valid) begin
        lat = n;
        break;
      end
    end
    req_valid = 1'b0;
    if (lat == 0) check("resp_timeout", 32'd0, 32'd1);
    else check("latency", lat, exp_lat);
    check("trace_len", trace.size(), ntr);
    for (int i = 0; i < ntr && i < trace.size(); i++) check("trace_addr", {16'h0, trace[i]}, {16'h0, tx[i]});
  endtask

  initial begin
    n_vec = 0; n_bad = 0; last_wm = '0;
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_sext = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
    mem[16'h0020] = 8'hAA; mem[16'h0021] = 8'h80;
    mem[16'h0030] = 8'h11; mem[16'h0031] = 8'h22;
    mem[16'h0040] = 8'h01; mem[16'h0041] = 8'h02; mem[16'h0042] = 8'h03; mem[16'h0043] = 8'h04;
    mem[16'h0050] = 8'h5A; mem[16'h0051] = 8'hA5;
    mem[16'h0060] = 8'h55; mem[16'h0061] = 8'h66;
    mem[16'hFFFE] = 8'h99; mem[16'hFFFF] = 8'h77; mem[16'h0000] = 8'h66; mem[16'h0001] = 8'h44;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_ready", {31'h0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    check("rst_rdata", {16'h0, resp_rdata}, 32'd0);
    check("rst_strobes", {30'h0, re, we}, 32'd0);
    check("rst_mem_alu", {31'h0, mem_alu}, 32'd1);

    do_req(0, 0, 0, 16'h0010, 16'h0000, 16'h1234, 2, 16'h0010, 0, 0, 0, 1, 0);
    do_req(0, 1, 1, 16'h0021, 16'h0000, 16'hFF80, 2, 16'h0020, 0, 0, 0, 1, 0);
    do_req(0, 1, 0, 16'h0021, 16'h0000, 16'h0080, 2, 16'h0020, 0, 0, 0, 1, 0);
    do_req(1, 1, 0, 16'h0031, 16'h00CC, 16'h0000, 3, 16'h0030, 16'h0030, 0, 0, 2, 1);
    check("bstore_wmdata", {16'h0, last_wm}, 32'h0000CC11);
    check("bstore_mem", {16'h0, mem[16'h0031], mem[16'h0030]}, 32'h0000CC11);
    check("busy_ignored", {16'h0, mem[16'h0051], mem[16'h0050]}, 32'h0000A55A);
    do_req(0, 0, 0, 16'h0041, 16'h0000, 16'h0302, 3, 16'h0040, 16'h0042, 0, 0, 2, 0);
    do_req(1, 0, 0, 16'h0041, 16'hBEEF, 16'h0000, 5, 16'h0040, 16'h0040, 16'h0042, 16'h0042, 4, 0);
    check("mstore_mem", {mem[16'h0043], mem[16'h0042], mem[16'h0041], mem[16'h0040]}, 32'h04BEEF01);
    do_req(1, 0, 0, 16'h0070, 16'hA5C3, 16'h0000, 2, 16'h0070, 0, 0, 0, 1, 0);
    do_req(0, 0, 0, 16'h0070, 16'h0000, 16'hA5C3, 2, 16'h0070, 0, 0, 0, 1, 0);
    do_req(1, 1, 0, 16'h0030, 16'h0077, 16'h0000, 3, 16'h0030, 16'h0030, 0, 0, 2, 0);
    check("bstore_even_wmdata", {16'h0, last_wm}, 32'h0000CC77);
    do_req(0, 0, 0, 16'h0030, 16'h0000, 16'hCC77, 2, 16'h0030, 0, 0, 0, 1, 0);
    do_req(0, 0, 0, 16'hFFFF, 16'h0000, 16'h6677, 3, 16'hFFFE, 16'h0000, 0, 0, 2, 0);

    // Reset during WR0 of a byte store to 0x0060: the write must not commit.
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_sext = 1'b0;
    req_addr = 16'h0060; req_wdata = 16'h00EE;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_pre_we", {31'h0, we}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_we_forced", {31'h0, we}, 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_mid_ready", {31'h0, req_ready}, 32'd1);
    check("rst_mid_resp", {31'h0, resp_valid}, 32'd0);
    check("rst_mid_mem", {16'h0, mem[16'h0061], mem[16'h0060]}, 32'h00006655);
    repeat (6) @(negedge clock);
    check("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
